memory_mode_responder: RTL and testbench

//  Memory-side responder for MemoryMode_t commands (LOAD, STORE_PRELOAD, STORE, NOP) from the core control logic.

---
 rtl/memory_mode_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_memory_mode_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_mode_responder.sv
// memory_mode_responder
// Memory-side responder for LOAD / STORE_PRELOAD / STORE / NOP commands.
// Converts RV32I byte/half/word accesses into word-only req/ack bus
// transactions. Sub-word stores use read-modify-write, and can reuse a word
// fetched earlier by STORE_PRELOAD. Load results are sign/zero extended.
module memory_mode_responder #(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [1:0]               memoryMode,
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [31:0]              rs2Data,
    output logic [31:0]              loadData,
    output logic                     done,
    output logic                     accessFault,
    output logic [ADDRESS_WIDTH-3:0] busAddress,
    output logic                     busReadRequest,
    output logic                     busWriteRequest,
    output logic [31:0]              busWriteData,
    input  logic [31:0]              busReadData,
    input  logic                     busAck
);

    localparam int WORD_AW = ADDRESS_WIDTH - 2;

    typedef enum logic [1:0] {
        MODE_LOAD          = 2'd0,
        MODE_STORE_PRELOAD = 2'd1,
        MODE_STORE         = 2'd2,
        MODE_NOP           = 2'd3
    } memory_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e             state;
    memory_mode_e       mode_q;
    logic [2:0]         funct3_q;
    logic [1:0]         offset_q;
    logic [31:0]        rs2_q;

    // Word fetched by a preload (or the read half of an RMW), reusable by a
    // following sub-word STORE to the same word.
    logic               preload_valid;
    logic [WORD_AW-1:0] preload_address;
    logic [31:0]        preload_buffer;

    memory_mode_e       mode_in;
    logic [WORD_AW-1:0] word_address;
    logic               cmd_fault;
    logic               cmd_word;
    logic               preload_hit;

    // Replace the addressed byte/half lanes of a word with store data;
    // a word store replaces everything.
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  offset,
        input logic [31:0] data
    );
        logic [31:0] result;
        result = word;
        case (f3[1:0])
            2'b00:   result[{offset, 3'b000} +: 8]     = data[7:0];
            2'b01:   result[{offset[1], 4'b0000} +: 16] = data[15:0];
            default: result = data;
        endcase
        return result;
    endfunction

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  offset
    );
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        logic [31:0] result;
        lane_byte = word[{offset, 3'b000} +: 8];
        lane_half = word[{offset[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  result = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  result = {{16{lane_half[15]}}, lane_half};
            3'b100:  result = {24'h000000, lane_byte};
            3'b101:  result = {16'h0000, lane_half};
            default: result = word;
        endcase
        return result;
    endfunction

    assign cmdReady     = (state == IDLE);
    assign mode_in      = memory_mode_e'(memoryMode);
    assign word_address = address[ADDRESS_WIDTH-1:2];
    assign cmd_word     = (funct3 == 3'b010);
    assign preload_hit  = preload_valid && (preload_address == word_address);

    // Classify the offered command: illegal width field or misaligned address.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cmd_fault = 1'b0;
        case (mode_in)
            MODE_LOAD:
                cmd_fault = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            MODE_STORE_PRELOAD, MODE_STORE:
                cmd_fault = funct3[2] || (funct3[1:0] == 2'b11);
            default:
                cmd_fault = 1'b0;
        endcase
        if (mode_in != MODE_NOP) begin
            if ((funct3[1:0] == 2'b01) && address[0])
                cmd_fault = 1'b1;
            if ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00))
                cmd_fault = 1'b1;
        end
    end

    // Command sequencing, bus handshakes and registered responses.
    always_ff @(posedge clock) begin
        // NOTE: all state uses non-blocking assignments so each register
        // samples pre-edge values of the others regardless of statement order.
        if (reset) begin
            // NOTE: the preload buffer is a single word, so it is reset along
            // with everything else; no reset-less storage array exists here.
            state           <= IDLE;
            mode_q          <= MODE_NOP;
            funct3_q        <= 3'b000;
            offset_q        <= 2'b00;
            rs2_q           <= 32'h0;
            loadData        <= 32'h0;
            done            <= 1'b0;
            accessFault     <= 1'b0;
            busAddress      <= '0;
            busReadRequest  <= 1'b0;
            busWriteRequest <= 1'b0;
            busWriteData    <= 32'h0;
            preload_valid   <= 1'b0;
            preload_address <= '0;
            preload_buffer  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        mode_q   <= mode_in;
                        funct3_q <= funct3;
                        offset_q <= address[1:0];
                        rs2_q    <= rs2Data;
                        if (cmd_fault) begin
                            state       <= RESP;
                            done        <= 1'b1;
                            accessFault <= 1'b1;
                            loadData    <= 32'h0;
                        end else begin
                            case (mode_in)
                                MODE_LOAD: begin
                                    state          <= READ;
                                    busReadRequest <= 1'b1;
                                    busAddress     <= word_address;
                                end
                                MODE_STORE_PRELOAD: begin
                                    if (cmd_word) begin
                                        // A full-word store needs no old data.
                                        state <= RESP;
                                        done  <= 1'b1;
                                    end else begin
                                        state          <= READ;
                                        busReadRequest <= 1'b1;
                                        busAddress     <= word_address;
                                    end
                                end
                                MODE_STORE: begin
                                    if (cmd_word) begin
                                        state           <= WRITE;
                                        busWriteRequest <= 1'b1;
                                        busAddress      <= word_address;
                                        busWriteData    <= rs2Data;
                                    end else if (preload_hit) begin
                                        state           <= WRITE;
                                        busWriteRequest <= 1'b1;
                                        busAddress      <= word_address;
                                        busWriteData    <= merge_store(preload_buffer, funct3,
                                                                       address[1:0], rs2Data);
                                    end else begin
                                        state          <= READ;
                                        busReadRequest <= 1'b1;
                                        busAddress     <= word_address;
                                    end
                                end
                                default: begin
                                    state <= RESP;
                                    done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                READ: begin
                    if (busAck) begin
                        busReadRequest <= 1'b0;
                        if (mode_q == MODE_LOAD) begin
                            loadData <= extend_load(busReadData, funct3_q, offset_q);
                            state    <= RESP;
                            done     <= 1'b1;
                        end else begin
                            preload_buffer  <= busReadData;
                            preload_valid   <= 1'b1;
                            preload_address <= busAddress;
                            if (mode_q == MODE_STORE) begin
                                state           <= WRITE;
                                busWriteRequest <= 1'b1;
                                busWriteData    <= merge_store(busReadData, funct3_q,
                                                               offset_q, rs2_q);
                            end else begin
                                state <= RESP;
                                done  <= 1'b1;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (busAck) begin
                        // Memory now differs from the buffered word.
                        busWriteRequest <= 1'b0;
                        preload_valid   <= 1'b0;
                        state           <= RESP;
                        done            <= 1'b1;
                    end
                end

                RESP: begin
                    done        <= 1'b0;
                    accessFault <= 1'b0;
                    loadData    <= 32'h0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_mode_responder.sv
// Testbench for memory_mode_responder: bus slave memory with programmable ack
// delay, directed vector table, reset-abort sequence and a randomized run
// checked against a behavioural model of the command rules.
module tb_memory_mode_responder;

    localparam logic [1:0] M_LOAD  = 2'd0;
    localparam logic [1:0] M_PRE   = 2'd1;
    localparam logic [1:0] M_STORE = 2'd2;
    localparam logic [1:0] M_NOP   = 2'd3;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        int          delay;
        int          lat;
        logic [31:0] ld;
        logic        flt;
        int          reads;
        int          writes;
        logic [31:0] wdata;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [1:0]  memoryMode = 2'd3;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'h0;
    logic [31:0] rs2Data = 32'h0;
    logic [31:0] loadData;
    logic        done;
    logic        accessFault;
    logic [29:0] busAddress;
    logic        busReadRequest;
    logic        busWriteRequest;
    logic [31:0] busWriteData;
    logic [31:0] busReadData;
    logic        busAck;

    int total = 0;
    int bad   = 0;

    memory_mode_responder #(.ADDRESS_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .memoryMode(memoryMode), .funct3(funct3), .address(address), .rs2Data(rs2Data),
        .loadData(loadData), .done(done), .accessFault(accessFault),
        .busAddress(busAddress), .busReadRequest(busReadRequest),
        .busWriteRequest(busWriteRequest), .busWriteData(busWriteData),
        .busReadData(busReadData), .busAck(busAck)
    );

    always #5 clock = ~clock;

    // ---------------- bus slave ----------------
    logic [31:0] mem [256];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          n_reads = 0;
    int          n_writes = 0;
    int          req_cycles = 0;
    logic [31:0] last_wdata = 32'h0;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'h0;
    logic [31:0] bd_data = 32'h0;

    always_comb begin
        busAck      = (busReadRequest || busWriteRequest) && (wait_cnt >= ack_delay);
        busReadData = mem[busAddress[7:0]];
    end

    always @(posedge clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (busAck) begin
            wait_cnt <= 0;
            if (busWriteRequest) begin
                mem[busAddress[7:0]] <= busWriteData;
                n_writes   <= n_writes + 1;
                last_wdata <= busWriteData;
            end else begin
                n_reads <= n_reads + 1;
            end
        end else if (busReadRequest || busWriteRequest) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        if (busReadRequest || busWriteRequest) req_cycles <= req_cycles + 1;
    end

    // ---------------- protocol monitor ----------------
    logic        rst_edge = 1'b1;
    logic        prev_pend = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [29:0] prev_addr = 30'h0;
    int          proto_err = 0;

    always @(posedge clock) rst_edge <= reset;

    always @(negedge clock) begin
        proto_err <= proto_err
                   + int'(busReadRequest && busWriteRequest)
                   + int'((busReadRequest || busWriteRequest) && (busAddress[29:8] != 22'h0))
                   + int'(prev_pend && !rst_edge &&
                          (busReadRequest != prev_rd || busWriteRequest != prev_wr ||
                           busAddress != prev_addr));
        prev_pend <= (busReadRequest || busWriteRequest) && !busAck;
        prev_rd   <= busReadRequest;
        prev_wr   <= busWriteRequest;
        prev_addr <= busAddress;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_mem [256];
    logic        m_pv = 1'b0;
    int          m_pa = 0;
    logic [31:0] m_pbuf = 32'h0;

    function automatic vec_t model_cmd(input logic [1:0] m, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] d,
                                       input int dly);
        vec_t        v;
        int          size;
        int          off;
        int          wa;
        logic        legal;
        logic [31:0] val;
        logic [31:0] base;
        v.mode = m; v.f3 = f3; v.addr = a; v.rs2 = d; v.delay = dly;
        v.lat = 1; v.ld = 32'h0; v.flt = 1'b0; v.reads = 0; v.writes = 0; v.wdata = 32'h0;
        if (m == M_NOP) return v;
        legal = (m == M_LOAD) ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        size  = 1 << f3[1:0];
        off   = int'(a[1:0]);
        wa    = int'(a[9:2]);
        if (!legal || (off % size) != 0) begin
            v.flt = 1'b1;
            return v;
        end
        if (m == M_LOAD) begin
            v.reads = 1;
            val = m_mem[wa] >> (8 * off);
            if (size == 1) begin
                val = val & 32'h000000FF;
                if (!f3[2] && val[7]) val = val | 32'hFFFFFF00;
            end else if (size == 2) begin
                val = val & 32'h0000FFFF;
                if (!f3[2] && val[15]) val = val | 32'hFFFF0000;
            end
            v.ld = val;
        end else if (m == M_PRE) begin
            if (size != 4) begin
                v.reads = 1;
                m_pv = 1'b1; m_pa = wa; m_pbuf = m_mem[wa];
            end
        end else begin
            if (size == 4) begin
                v.wdata = d;
            end else begin
                if (m_pv && m_pa == wa) begin
                    base = m_pbuf;
                end else begin
                    v.reads = 1;
                    base = m_mem[wa];
                end
                for (int i = 0; i < size; i++) base[8*(off+i) +: 8] = d[8*i +: 8];
                v.wdata = base;
            end
            v.writes = 1;
            m_mem[wa] = v.wdata;
            m_pv = 1'b0;
        end
        v.lat = 1 + (v.reads + v.writes) * (1 + dly);
        return v;
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input int dly, input int lat,
                                input logic [31:0] ld, input logic flt, input int r, input int w,
                                input logic [31:0] wd);
        vec_t v;
        v.mode = m; v.f3 = f3; v.addr = a; v.rs2 = d; v.delay = dly; v.lat = lat;
        v.ld = ld; v.flt = flt; v.reads = r; v.writes = w; v.wdata = wd;
        return v;
    endfunction

    // ---------------- tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input int wa, input logic [31:0] val);
        bd_we = 1'b1; bd_addr = wa[7:0]; bd_data = val;
        @(negedge clock);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_pv = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] m, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] ld,
                          output logic flt, output int rdy_bad);
        int guard;
        guard = 0;
        rdy_bad = 0;
        while (!cmdReady && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        memoryMode = m; funct3 = f3; address = a; rs2Data = d; cmdValid = 1'b1;
        @(negedge clock);
        cmdValid = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (cmdReady) rdy_bad++;
            @(negedge clock);
            lat++;
        end
        if (cmdReady) rdy_bad++;
        ld  = loadData;
        flt = accessFault;
        @(negedge clock);
        check("done_pulse", {31'h0, done}, 32'h0);
        check("ready_after", {31'h0, cmdReady}, 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          r0, w0, q0, lat, rdy_bad;
        logic [31:0] ld;
        logic        flt;
        ack_delay = v.delay;
        r0 = n_reads; w0 = n_writes; q0 = req_cycles;
        do_cmd(v.mode, v.f3, v.addr, v.rs2, lat, ld, flt, rdy_bad);
        check($sformatf("%s/latency", tag), lat, v.lat);
        check($sformatf("%s/fault", tag), {31'h0, flt}, {31'h0, v.flt});
        if (v.mode == M_LOAD) check($sformatf("%s/loadData", tag), ld, v.ld);
        check($sformatf("%s/reads", tag), n_reads - r0, v.reads);
        check($sformatf("%s/writes", tag), n_writes - w0, v.writes);
        if (v.writes > 0) check($sformatf("%s/wdata", tag), last_wdata, v.wdata);
        if (v.reads + v.writes == 0) check($sformatf("%s/no_request", tag), req_cycles - q0, 0);
        check($sformatf("%s/ready_low", tag), rdy_bad, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [1:0] rm;
        int wa;
        logic [31:0] rv;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst/cmdReady", {31'h0, cmdReady}, 32'h1);
        check("rst/done", {31'h0, done}, 32'h0);
        check("rst/accessFault", {31'h0, accessFault}, 32'h0);
        check("rst/loadData", loadData, 32'h0);
        check("rst/busAddress", {2'b00, busAddress}, 32'h0);
        check("rst/busReadRequest", {31'h0, busReadRequest}, 32'h0);
        check("rst/busWriteRequest", {31'h0, busWriteRequest}, 32'h0);
        check("rst/busWriteData", busWriteData, 32'h0);

        poke(32'h40, 32'h8070F0A5);
        poke(32'h80, 32'h11223344);
        poke(32'h81, 32'h11223344);

        //          mode     f3    addr        rs2          dly lat ld            flt r  w  wdata
        tbl.push_back(mk(M_LOAD,  3'd0, 32'h100, 32'h0,        0, 2, 32'hFFFFFFA5, 0, 1, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd4, 32'h103, 32'h0,        0, 2, 32'h00000080, 0, 1, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd1, 32'h102, 32'h0,        0, 2, 32'hFFFF8070, 0, 1, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd5, 32'h100, 32'h0,        0, 2, 32'h0000F0A5, 0, 1, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd2, 32'h100, 32'h0,        3, 5, 32'h8070F0A5, 0, 1, 0, 32'h0));
        tbl.push_back(mk(M_PRE,   3'd0, 32'h201, 32'h0,        0, 2, 32'h0,        0, 1, 0, 32'h0));
        tbl.push_back(mk(M_STORE, 3'd0, 32'h201, 32'h000000AB, 0, 2, 32'h0,        0, 0, 1, 32'h1122AB44));
        tbl.push_back(mk(M_STORE, 3'd2, 32'h200, 32'hCAFEF00D, 0, 2, 32'h0,        0, 0, 1, 32'hCAFEF00D));
        tbl.push_back(mk(M_STORE, 3'd1, 32'h206, 32'h0000BEEF, 0, 3, 32'h0,        0, 1, 1, 32'hBEEF3344));
        tbl.push_back(mk(M_LOAD,  3'd2, 32'h102, 32'h0,        0, 1, 32'h0,        1, 0, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd1, 32'h101, 32'h0,        0, 1, 32'h0,        1, 0, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd3, 32'h100, 32'h0,        0, 1, 32'h0,        1, 0, 0, 32'h0));
        tbl.push_back(mk(M_STORE, 3'd4, 32'h200, 32'h0,        0, 1, 32'h0,        1, 0, 0, 32'h0));
        tbl.push_back(mk(M_NOP,   3'd0, 32'h100, 32'h0,        0, 1, 32'h0,        0, 0, 0, 32'h0));
        tbl.push_back(mk(M_PRE,   3'd2, 32'h200, 32'h0,        0, 1, 32'h0,        0, 0, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd2, 32'h200, 32'h0,        0, 2, 32'hCAFEF00D, 0, 1, 0, 32'h0));
        tbl.push_back(mk(M_STORE, 3'd0, 32'h207, 32'h12345677, 1, 5, 32'h0,        0, 1, 1, 32'h77EF3344));
        tbl.push_back(mk(M_PRE,   3'd1, 32'h204, 32'h0,        0, 2, 32'h0,        0, 1, 0, 32'h0));
        tbl.push_back(mk(M_LOAD,  3'd0, 32'h204, 32'h0,        0, 2, 32'h00000044, 0, 1, 0, 32'h0));
        tbl.push_back(mk(M_STORE, 3'd1, 32'h204, 32'hFFFF1234, 0, 2, 32'h0,        0, 0, 1, 32'h77EF1234));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while a read is pending must discard the preload as well.
        run_vec(mk(M_PRE, 3'd0, 32'h100, 32'h0, 0, 2, 32'h0, 0, 1, 0, 32'h0), "abort_pre");
        ack_delay = 20;
        memoryMode = M_LOAD; funct3 = 3'd2; address = 32'h100; cmdValid = 1'b1;
        @(negedge clock);
        cmdValid = 1'b0;
        @(negedge clock);
        check("abort/req_before", {31'h0, busReadRequest}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort/busReadRequest", {31'h0, busReadRequest}, 32'h0);
        check("abort/busWriteRequest", {31'h0, busWriteRequest}, 32'h0);
        check("abort/cmdReady", {31'h0, cmdReady}, 32'h1);
        check("abort/done", {31'h0, done}, 32'h0);
        run_vec(mk(M_STORE, 3'd0, 32'h100, 32'h0000005A, 0, 3, 32'h0, 0, 1, 1, 32'h8070F05A),
                "abort_store");

        // Randomized run against the model on freshly initialised memory.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rv = $urandom;
            poke(i, rv);
            m_mem[i] = rv;
        end
        for (int i = 0; i < 300; i++) begin
            rm = 2'($urandom_range(0, 3));
            wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            v = model_cmd(rm, 3'($urandom_range(0, 7)),
                          32'(wa * 4 + int'($urandom_range(0, 3))),
                          $urandom, int'($urandom_range(0, 2)));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        check("protocol", proto_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
